// File: rtl/dst40_sweep_ctrl.sv
// Sweep controller for one array of NK DST40 hashing kernels.
//
// Issues one kernel key per run cycle to the whole array and tracks, in a second
// key register, which key's result is on cmp_i right now. The two registers are
// PIPE_LAT run cycles apart. The sweep ends on the first hit or after the last key's
// result has been checked.
//
// Ports:
//   clock_i      clock
//   reset_i      synchronous reset, active-high
//   start_i      start a sweep (honoured in IDLE or DONE)
//   abort_i      return to IDLE, keep found_o / found_key_o
//   pause_i      hold run_o low, freezing the kernel pipeline
//   key_start_i  first kernel key of the sweep
//   key_end_i    last kernel key of the sweep (inclusive, compared live)
//   cmp_i        comparator outputs, bit k from kernel k
//   run_o        run enable to all kernels
//   key_o        kernel key to all kernels
//   busy_o       high while sweeping or draining
//   done_o       high in DONE
//   found_o      a match was captured
//   found_key_o  {kernel index, kernel key} of the match
module dst40_sweep_ctrl #(
  parameter int unsigned NK       = 2,
  parameter int unsigned L2NK     = 1,
  parameter int unsigned PIPE_LAT = 64,
  localparam int unsigned KW      = 40 - L2NK
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            pause_i,
  input  logic [KW-1:0]   key_start_i,
  input  logic [KW-1:0]   key_end_i,
  input  logic [NK-1:0]   cmp_i,
  output logic            run_o,
  output logic [KW-1:0]   key_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            found_o,
  output logic [39:0]     found_key_o
);

  localparam int unsigned FW = $clog2(PIPE_LAT + 1);
  localparam logic [FW-1:0] FillMax = FW'(PIPE_LAT);

  typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   key_q, key_d;
  logic [KW-1:0]   res_key_q, res_key_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            found_q, found_d;
  logic [39:0]     found_key_q, found_key_d;

  logic            run;
  logic [L2NK-1:0] hit_idx;

  // Lowest set bit of cmp_i wins: scan from the top so lower indices overwrite.
  always_comb begin
    hit_idx = '0;
    for (int k = NK - 1; k >= 0; k--) begin
      if (cmp_i[k]) hit_idx = L2NK'(k);
    end
  end

  assign run = ((state_q == StSweep) || (state_q == StDrain)) && !pause_i;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    res_key_d   = res_key_q;
    fill_d      = fill_q;
    found_d     = found_q;
    found_key_d = found_key_q;

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d     = StSweep;
          key_d       = key_start_i;
          res_key_d   = key_start_i;
          fill_d      = '0;
          found_d     = 1'b0;
          found_key_d = '0;
        end
      end
      StSweep, StDrain: begin
        if (run) begin
          if (fill_q != FillMax) fill_d = fill_q + FW'(1);

          if (state_q == StSweep) begin
            if (key_q != key_end_i) key_d = key_q + KW'(1);
            else                    state_d = StDrain;
          end

          // Result check comes last so DONE overrides the SWEEP->DRAIN step.
          if (fill_q == FillMax) begin
            if (cmp_i != '0) begin
              found_key_d = {hit_idx, res_key_q};
              found_d     = 1'b1;
              state_d     = StDone;
            end else if (res_key_q == key_end_i) begin
              state_d = StDone;
            end else begin
              res_key_d = res_key_q + KW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort discards everything decided above, including a same-cycle hit or start.
    if (abort_i) begin
      state_d     = StIdle;
      key_d       = key_q;
      res_key_d   = res_key_q;
      fill_d      = fill_q;
      found_d     = found_q;
      found_key_d = found_key_q;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      key_q       <= '0;
      res_key_q   <= '0;
      fill_q      <= '0;
      found_q     <= 1'b0;
      found_key_q <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      res_key_q   <= res_key_d;
      fill_q      <= fill_d;
      found_q     <= found_d;
      found_key_q <= found_key_d;
    end
  end

  assign run_o       = run;
  assign key_o       = key_q;
  assign busy_o      = (state_q == StSweep) || (state_q == StDrain);
  assign done_o      = (state_q == StDone);
  assign found_o     = found_q;
  assign found_key_o = found_key_q;

endmodule

// File: tb/tb_dst40_sweep_ctrl.sv
// Directed bench for dst40_sweep_ctrl (NK=2, PIPE_LAT=4).
// A small kernel-array model delays key_o by LAT run cycles and raises hit_mask on
// cmp when the delayed key equals hit_key. Inputs are driven and outputs sampled on
// the falling edge.
module tb_dst40_sweep_ctrl;

  localparam int unsigned NK   = 2;
  localparam int unsigned L2NK = 1;
  localparam int unsigned LAT  = 4;
  localparam int unsigned KW   = 40 - L2NK;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          pause = 1'b0;
  logic [KW-1:0] key_start = '0;
  logic [KW-1:0] key_end = '0;
  logic [NK-1:0] cmp;
  logic          run;
  logic [KW-1:0] key;
  logic          busy;
  logic          done;
  logic          found;
  logic [39:0]   found_key;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dst40_sweep_ctrl #(
    .NK       (NK),
    .L2NK     (L2NK),
    .PIPE_LAT (LAT)
  ) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .start_i     (start),
    .abort_i     (abort),
    .pause_i     (pause),
    .key_start_i (key_start),
    .key_end_i   (key_end),
    .cmp_i       (cmp),
    .run_o       (run),
    .key_o       (key),
    .busy_o      (busy),
    .done_o      (done),
    .found_o     (found),
    .found_key_o (found_key)
  );

  // Kernel array model.
  logic [KW-1:0]  pipe_key [LAT];
  logic [LAT-1:0] pipe_vld = '0;
  logic [KW-1:0]  hit_key  = '0;
  logic [NK-1:0]  hit_mask = '0;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      pipe_vld <= '0;
    end else if (run) begin
      pipe_vld    <= {pipe_vld[LAT-2:0], 1'b1};
      pipe_key[0] <= key;
      for (int i = 1; i < LAT; i++) pipe_key[i] <= pipe_key[i-1];
    end
  end

  assign cmp = (pipe_vld[LAT-1] && (pipe_key[LAT-1] == hit_key)) ? hit_mask : '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Returns at the falling edge of the first run cycle.
  task automatic do_start(input logic [KW-1:0] s, input logic [KW-1:0] e);
    key_start = s;
    key_end   = e;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    check_eq("rst_run",   64'(run),       0);
    check_eq("rst_key",   64'(key),       0);
    check_eq("rst_busy",  64'(busy),      0);
    check_eq("rst_done",  64'(done),      0);
    check_eq("rst_found", 64'(found),     0);
    check_eq("rst_fkey",  64'(found_key), 0);

    // 1: four keys, no hit; done 8 cycles after the first run cycle.
    hit_mask = 2'b00;
    do_start(39'h10, 39'h13);
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        check_eq("t1_key", 64'(key), 64'(39'h10 + 39'(c)));
        check_eq("t1_run", 64'(run), 1);
      end
      check_eq("t1_notdone", 64'(done), 0);
      step(1);
    end
    check_eq("t1_done",  64'(done),  1);
    check_eq("t1_found", 64'(found), 0);
    check_eq("t1_key_hold", 64'(key), 64'(39'h13));
    check_eq("t1_run_off", 64'(run), 0);

    // 2: hit on kernel 1 at key 0x12; restart directly from DONE.
    hit_key  = 39'h12;
    hit_mask = 2'b10;
    do_start(39'h10, 39'h13);
    step(6);
    check_eq("t2_notdone", 64'(done), 0);
    step(1);
    check_eq("t2_done",  64'(done),      1);
    check_eq("t2_found", 64'(found),     1);
    check_eq("t2_fkey",  64'(found_key), 64'({1'b1, 39'h12}));
    step(2);
    check_eq("t2_run_off",  64'(run),       0);
    check_eq("t2_key_hold", 64'(key),       64'(39'h13));
    check_eq("t2_fkey_hold", 64'(found_key), 64'({1'b1, 39'h12}));

    // 3: same hit with a 3-cycle pause while key 0x12 is presented.
    do_start(39'h10, 39'h13);
    step(2);
    for (int p = 0; p < 3; p++) begin
      pause = 1'b1;
      #1;
      check_eq("t3_pause_run", 64'(run), 0);
      check_eq("t3_pause_key", 64'(key), 64'(39'h12));
      @(negedge clk);
    end
    pause = 1'b0;
    #1;
    check_eq("t3_resume_run", 64'(run), 1);
    check_eq("t3_resume_key", 64'(key), 64'(39'h12));
    step(4);
    check_eq("t3_notdone", 64'(done), 0);
    step(1);
    check_eq("t3_done", 64'(done),      1);
    check_eq("t3_fkey", 64'(found_key), 64'({1'b1, 39'h12}));

    // 4: wrap through all-ones to zero, no hit.
    hit_mask = 2'b00;
    do_start(39'h7F_FFFF_FFFE, 39'h1);
    check_eq("t4_found_clr", 64'(found), 0);
    check_eq("t4_k0", 64'(key), 64'(39'h7F_FFFF_FFFE));
    step(1);
    check_eq("t4_k1", 64'(key), 64'(39'h7F_FFFF_FFFF));
    step(1);
    check_eq("t4_k2", 64'(key), 0);
    step(1);
    check_eq("t4_k3", 64'(key), 1);
    step(5);
    check_eq("t4_done",  64'(done),  1);
    check_eq("t4_found", 64'(found), 0);

    // 5: both kernels hit on key 0x11; lowest index wins.
    hit_key  = 39'h11;
    hit_mask = 2'b11;
    do_start(39'h10, 39'h13);
    step(6);
    check_eq("t5_done", 64'(done),      1);
    check_eq("t5_fkey", 64'(found_key), 64'({1'b0, 39'h11}));

    // 6: abort from DONE keeps the result.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t6_done",  64'(done),      0);
    check_eq("t6_found", 64'(found),     1);
    check_eq("t6_fkey",  64'(found_key), 64'({1'b0, 39'h11}));

    // 7: restart clears found; mid-sweep abort returns to IDLE.
    hit_mask = 2'b00;
    do_start(39'h10, 39'h13);
    check_eq("t7_found_clr", 64'(found), 0);
    check_eq("t7_busy", 64'(busy), 1);
    step(2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t7_abort_run",  64'(run),  0);
    check_eq("t7_abort_busy", 64'(busy), 0);
    check_eq("t7_abort_done", 64'(done), 0);

    // abort beats start in the same cycle.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_eq("t7_abort_wins", 64'(busy), 0);

    // 8: restart from key_start, then mid-sweep reset.
    do_start(39'h20, 39'h22);
    check_eq("t8_key0", 64'(key),  64'(39'h20));
    check_eq("t8_run",  64'(run),  1);
    step(2);
    check_eq("t8_key2", 64'(key), 64'(39'h22));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t8_rst_run",   64'(run),       0);
    check_eq("t8_rst_key",   64'(key),       0);
    check_eq("t8_rst_busy",  64'(busy),      0);
    check_eq("t8_rst_done",  64'(done),      0);
    check_eq("t8_rst_found", 64'(found),     0);
    check_eq("t8_rst_fkey",  64'(found_key), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dst40_sweep_ctrl.md
Name: dst40_sweep_ctrl

Overview:
- Sweep controller for one array of NK DST40 hashing kernels.
- Upstream side: issues one key per enabled clock, plus the shared run enable, to the kernel array.
- Downstream side: consumes the NK comparator outputs. It compensates for the fixed pipeline latency of the kernels, so a match is attributed to the exact 40-bit key that produced it.
- Stops on the first hit, or when the programmed key range is exhausted.

Parameters:
- NK, 2, number of kernels in the array (kernel k supplies key bits [39:40-L2NK] = k).
- L2NK, 1, log2(NK); the kernel key width is KW = 40-L2NK.
- PIPE_LAT, 64, number of run-enabled clocks from presenting a key on key_o to the matching comparator bit appearing on cmp_i (must be ≥1).

Ports:
- clock_i  in  1  clock
- reset_i  in  1  synchronous reset, active-high
- start_i  in  1  one-cycle pulse that starts a sweep; honoured only in IDLE or DONE
- abort_i  in  1  return to IDLE; found_o and found_key_o keep their values
- pause_i  in  1  while high, run_o=0 and the kernel pipeline freezes
- key_start_i  in  KW  first kernel key of the sweep
- key_end_i  in  KW  last kernel key of the sweep (inclusive)
- cmp_i  in  NK  comparator outputs; bit k comes from kernel k
- run_o  out  1  run enable to all kernels
- key_o  out  KW  kernel key to all kernels
- busy_o  out  1  high in SWEEP or DRAIN
- done_o  out  1  high in DONE
- found_o  out  1  a match was captured
- found_key_o  out  40  {kernel index, kernel key} of the match

Behaviour:
- Reset values: state=IDLE; run_o=0; key_o=0; busy_o=0; done_o=0; found_o=0; found_key_o=0; all internal counters 0.
- Definition: a run cycle is any clock with run_o=1.
- Definition: fill is a counter of run cycles since start, saturating at PIPE_LAT.
- Definition: res_key is the kernel key whose result is on cmp_i during the current run cycle.
- IDLE: on start_i, load key_o=key_start_i and res_key=key_start_i, clear fill, clear found_o and found_key_o, then go to SWEEP.
- SWEEP:
  - run_o = !pause_i.
  - On each run cycle with key_o != key_end_i, key_o increments modulo 2^KW.
  - On a run cycle with key_o == key_end_i, key_o holds its value and the state goes to DRAIN.
- DRAIN:
  - run_o = !pause_i; key_o holds.
  - Duplicate keys issued during DRAIN are never evaluated.
- Result check, applied in both SWEEP and DRAIN:
  - Performed only on a run cycle in which fill == PIPE_LAT before the update.
  - If cmp_i != 0: capture found_key_o = {k, res_key}, where k is the lowest set bit index of cmp_i. Then set found_o=1, go to DONE, and set run_o=0 from the next cycle.
  - Else if res_key == key_end_i: go to DONE with found_o=0.
  - Else res_key increments modulo 2^KW.
  - A hit has priority over range-end in the same cycle.
- Alignment: cmp_i in run cycle n corresponds to the key_o of run cycle n-PIPE_LAT. Paused cycles do not count toward this.
- Wrap-around:
  - key_end_i < key_start_i sweeps through all-ones to 0.
  - key_end_i == key_start_i sweeps exactly one key.
  - The full space is start = end+1.
- DONE: run_o=0, done_o=1, outputs held. start_i restarts the sweep exactly as from IDLE.
- abort_i in any state:
  - Next cycle: IDLE, run_o=0, busy_o=0, done_o=0.
  - abort_i wins over start_i and over a hit in the same cycle.
- reset_i overrides everything, including a sweep in progress. All outputs return to their reset values in the next cycle.
- Range inputs are sampled only at start. Changes during a sweep are ignored, except that key_end_i is compared live. Integration must therefore hold key_end_i stable for the whole sweep.
- Latency from start_i to the first run_o=1 is 1 cycle. With no pause, total sweep time for N keys is N+PIPE_LAT cycles to done_o.

Test Plan:
- NK=2, PIPE_LAT=4, start=0x10, end=0x13, no pause:
  - Bench drives cmp_i=0 throughout.
  - Required: key_o steps 0x10..0x13, then holds.
  - Required: done_o=1 with found_o=0 exactly 8 cycles after the first run cycle.
- Same range; the bench model asserts cmp_i=2'b10 in the run cycle aligned with key 0x12.
  - Required: found_key_o={1'b1,39'h12}, found_o=1, done_o=1.
  - Required: no further keys are evaluated.
- Same hit as above, with pause_i held for 3 cycles mid-sweep.
  - Required: run_o=0 and key_o frozen during the pause.
  - Required: the hit is still attributed to 0x12.
- cmp_i=2'b11 on the aligned key 0x11 → found_key_o={1'b0,39'h11}, i.e. the lowest index wins.
- Wrap case: start=all-ones−1, end=1, no hit.
  - Required: key_o sequence is FF..FE, FF..FF, 0, 1.
  - Required: done_o is reached with found_o=0.
- Mid-sweep abort_i → IDLE next cycle with run_o=0. A later start_i clears found_o and restarts from key_start_i. Mid-sweep reset_i → all outputs return to their reset values next cycle.
